pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Fetch-side controller for the two-stage (FETCH/EX) MIPS core. Owns the fetch PC,
//  the instruction-register load enable and the EX valid bit; resolves branch, jump
//  and jump-register redirects from EX, squashes the wrong-path fetch, honours
//  multicycle holds and a halt instruction. Counts retired instructions.
// PARAMETERS
//  ADDR_W     12   word-address width of instruction memory (PC width)
//  RESET_PC   0    fetch PC after reset
// PORTS
//  clk            in   1       clock
//  rst            in   1       reset
//  pc_src_ex      in   2       EX redirect kind: 00 seq, 01 branch, 10 jump, 11 jr
//  branch_take_ex in   1       branch condition true (from ALU zero/compare)
//  imm_ex         in   16      branch offset, signed, in words
//  jtarget_ex     in   26      jump target field, word address
//  jr_target_ex   in   32      rs value for jr/jalr, word address
//  halt_ex        in   1       EX instruction is halt/break
//  hold           in   1       external stall (multicycle ALU op in EX)
//  pc_fetch       out  ADDR_W  instruction memory read address
//  ir_load        out  1       enable for the EX instruction register
//  ex_valid       out  1       EX instruction valid; CU gates regwrite/GPIO with it
//  pc_ex          out  ADDR_W  PC of instruction in EX
//  link_ex        out  ADDR_W  pc_ex+1 (jal/jalr link value)
//  halted         out  1       core halted
//  instret        out  32      retired-instruction count
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high. Reset (any cycle, mid-op
//    included) at next edge: pc_fetch=RESET_PC, pc_ex=0, ex_valid=0, ir_load=1,
//    halted=0, instret=0, state=FILL.
//  - Imem read combinational from pc_fetch; EX register captures on edge with ir_load.
//  - States: FILL (EX empty) -> RUN next cycle; RUN; SQUASH; HALTED.
//  - redirect = ex_valid & (pc_src_ex==10 | pc_src_ex==11 | (pc_src_ex==01 & branch_take_ex)).
//  - Targets (mod 2^ADDR_W): branch = pc_ex+1+sext(imm_ex); jump = jtarget_ex[ADDR_W-1:0];
//    jr = jr_target_ex[ADDR_W-1:0]. No delay slot.
//  - RUN, no hold, no redirect: pc_fetch<=pc_fetch+1 (wraps max->0), pc_ex<=pc_fetch,
//    ex_valid<=1.
//  - RUN, redirect, no hold: pc_fetch<=target; wrong-path word is loaded but
//    ex_valid<=0 (state SQUASH); target instruction valid in EX two edges after the
//    redirect cycle. Penalty exactly 1 bubble. SQUASH -> RUN next cycle, fetching normally.
//  - hold=1 (any state but HALTED): ir_load=0; pc_fetch, pc_ex, ex_valid, state frozen;
//    hold beats redirect and halt; redirect re-evaluated after hold drops.
//  - halt_ex & ex_valid & !hold: state<=HALTED; ex_valid<=0; ir_load=0 and
//    pc_fetch frozen until rst; halted=1 from next cycle. halt beats redirect.
//  - Inputs ignored whenever ex_valid=0 (FILL/SQUASH bubbles never redirect or halt).
//  - instret += 1 each cycle ex_valid & !hold (incl. the halt instruction); wraps 2^32.
//  - link_ex combinational; all other outputs registered or decoded from state.
// STRUCTURE
//  - cpu_pkg: pc_src_e enum {PC_SEQ, PC_BR, PC_J, PC_JR}; seq_state_e enum
//    {FILL, RUN, SQUASH, HALTED}; RESET_PC default constant.
//  - Sub-module pc_target_calc: combinational target mux + sign extension.
//  - Single always_ff for state/PC/valid/counter; always_comb for redirect/ir_load.
// TESTING
//  - Reset then 5 free cycles, no redirects -> pc_fetch 0..5, ex_valid 0 then 1,
//    pc_ex trails by one, instret=4 after cycle 5.
//  - Branch at pc_ex=8, imm=-3, take=1 -> pc_fetch=6 next; ex_valid=0 one cycle;
//    pc_ex=6 valid after; same with take=0 -> sequential, no bubble.
//  - jr at pc_ex=3, jr_target_ex=0x0000_1FFF, ADDR_W=12 -> pc_fetch=0xFFF; link_ex=4;
//    then sequential fetch wraps 0xFFF->0x000.
//  - hold=1 three cycles on a taken jump to 0x40 -> pc_fetch/pc_ex/instret frozen,
//    ir_load=0; jump to 0x40 takes effect the cycle hold drops.
//  - halt_ex with taken branch same cycle -> HALTED, halted=1, pc_fetch frozen,
//    instret stops; rst mid-halt -> pc_fetch=0, halted=0 next edge.
//  - Redirect asserted during SQUASH/FILL bubble (ex_valid=0) -> ignored, PC sequential.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared types and constants for the two-stage MIPS fetch/EX front end.
package cpu_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        FILL   = 2'b00,
        RUN    = 2'b01,
        SQUASH = 2'b10,
        HALTED = 2'b11
    } seq_state_e;

    localparam int          ADDR_W_DEF   = 12;
    localparam int unsigned RESET_PC_DEF = 32'd0;

    // Branch offsets are signed 16-bit word counts.
    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/pc_target_calc.sv
// Redirect target mux: branch (pc_ex+1+offset), jump field or jr register,
// all reduced modulo the instruction-memory size.
module pc_target_calc
    import cpu_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [1:0]        pc_src,
    input  logic [ADDR_W-1:0] pc_ex,
    input  logic [15:0]       imm,
    input  logic [25:0]       jtarget,
    input  logic [31:0]       jr_target,
    output logic [ADDR_W-1:0] target
);

    logic [31:0] br_full_s;
    logic [31:0] seq_full_s;

    // Select the redirect target for the instruction currently in EX.
    always_comb begin
        br_full_s  = 32'(pc_ex) + 32'd1 + sext16(imm);
        seq_full_s = 32'(pc_ex) + 32'd1;
        case (pc_src_e'(pc_src))
            PC_BR:   target = br_full_s[ADDR_W-1:0];
            PC_J:    target = jtarget[ADDR_W-1:0];
            PC_JR:   target = jr_target[ADDR_W-1:0];
            default: target = seq_full_s[ADDR_W-1:0];
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side sequencer: owns fetch PC, EX valid bit and IR load, resolves
// EX redirects with a single squashed bubble, honours hold and halt.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned RESET_PC = RESET_PC_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        pc_src_ex,
    input  logic              branch_take_ex,
    input  logic [15:0]       imm_ex,
    input  logic [25:0]       jtarget_ex,
    input  logic [31:0]       jr_target_ex,
    input  logic              halt_ex,
    input  logic              hold,
    output logic [ADDR_W-1:0] pc_fetch,
    output logic              ir_load,
    output logic              ex_valid,
    output logic [ADDR_W-1:0] pc_ex,
    output logic [ADDR_W-1:0] link_ex,
    output logic              halted,
    output logic [31:0]       instret
);

    seq_state_e        state_r;
    logic [ADDR_W-1:0] pc_fetch_r;
    logic [ADDR_W-1:0] pc_ex_r;
    logic              ex_valid_r;
    logic [31:0]       instret_r;
    logic [ADDR_W-1:0] target_s;
    logic              redirect_s;
    logic              halt_s;
    logic              ir_load_s;
    logic [ADDR_W-1:0] pc_next_seq_s;

    pc_target_calc #(.ADDR_W(ADDR_W)) u_target (
        .pc_src    (pc_src_ex),
        .pc_ex     (pc_ex_r),
        .imm       (imm_ex),
        .jtarget   (jtarget_ex),
        .jr_target (jr_target_ex),
        .target    (target_s)
    );

    // Decode redirect/halt from EX; bubbles (ex_valid=0) never act.
    always_comb begin
        redirect_s    = 1'b0;
        halt_s        = 1'b0;
        ir_load_s     = 1'b0;
        pc_next_seq_s = pc_fetch_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        case (pc_src_e'(pc_src_ex))
            PC_J, PC_JR: redirect_s = ex_valid_r;
            PC_BR:       redirect_s = ex_valid_r & branch_take_ex;
            default:     redirect_s = 1'b0;
        endcase
        if (ex_valid_r && halt_ex && !hold) begin
            halt_s = 1'b1;
        end else begin
            halt_s = 1'b0;
        end
        if (state_r == HALTED) begin
            ir_load_s = 1'b0;
        end else begin
            ir_load_s = ~hold;
        end
    end

    // Sequencer state, PCs, EX valid and retired-instruction counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= FILL;
            pc_fetch_r <= RESET_PC[ADDR_W-1:0];
            pc_ex_r    <= '0;
            ex_valid_r <= 1'b0;
            instret_r  <= 32'd0;
        end else begin
            if (ex_valid_r && !hold) begin
                instret_r <= instret_r + 32'd1;
            end
            case (state_r)
                FILL, RUN, SQUASH: begin
                    if (hold) begin
                        state_r <= state_r;
                    end else if (halt_s) begin
                        // Halt outranks any redirect decoded in the same cycle.
                        state_r    <= HALTED;
                        ex_valid_r <= 1'b0;
                    end else if (redirect_s) begin
                        state_r    <= SQUASH;
                        pc_fetch_r <= target_s;
                        pc_ex_r    <= pc_fetch_r;
                        ex_valid_r <= 1'b0;
                    end else begin
                        state_r    <= RUN;
                        pc_fetch_r <= pc_next_seq_s;
                        pc_ex_r    <= pc_fetch_r;
                        ex_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= HALTED;
                    ex_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign pc_fetch = pc_fetch_r;
    assign pc_ex    = pc_ex_r;
    assign ex_valid = ex_valid_r;
    assign instret  = instret_r;
    assign ir_load  = ir_load_s;
    assign halted   = (state_r == HALTED);
    assign link_ex  = pc_ex_r + {{(ADDR_W-1){1'b0}}, 1'b1};

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed vector table plus randomized run against
// a behavioural model of the fetch/EX rules.
module tb_pc_sequencer;

    localparam int AW   = 12;
    localparam int MASK = 32'h0000_0FFF;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [1:0]    pc_src_ex = 2'd0;
    logic          branch_take_ex = 1'b0;
    logic [15:0]   imm_ex = 16'd0;
    logic [25:0]   jtarget_ex = 26'd0;
    logic [31:0]   jr_target_ex = 32'd0;
    logic          halt_ex = 1'b0;
    logic          hold = 1'b0;
    logic [AW-1:0] pc_fetch;
    logic          ir_load;
    logic          ex_valid;
    logic [AW-1:0] pc_ex;
    logic [AW-1:0] link_ex;
    logic          halted;
    logic [31:0]   instret;

    always #5 clk = ~clk;

    pc_sequencer #(.ADDR_W(AW), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .pc_src_ex(pc_src_ex), .branch_take_ex(branch_take_ex),
        .imm_ex(imm_ex), .jtarget_ex(jtarget_ex), .jr_target_ex(jr_target_ex),
        .halt_ex(halt_ex), .hold(hold), .pc_fetch(pc_fetch), .ir_load(ir_load),
        .ex_valid(ex_valid), .pc_ex(pc_ex), .link_ex(link_ex), .halted(halted),
        .instret(instret)
    );

    typedef struct {
        logic        rst;
        logic [1:0]  src;
        logic        take;
        logic [15:0] imm;
        logic [25:0] jt;
        logic [31:0] jr;
        logic        halt;
        logic        hold;
        int          pf;
        logic        v;
        int          pex;
        int          inst;
        logic        h;
    } vec_t;

    vec_t tab[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference state: what the fetch/EX pipeline holds after each edge.
    int          m_pf, m_pex;
    logic [31:0] m_inst;
    logic        m_v, m_h;
    bit          m_ok = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic [1:0] s, input logic tk, input logic [15:0] im,
                       input logic [25:0] j, input logic [31:0] jrv, input logic hl, input logic hd,
                       input int pf, input logic v, input int pex, input int inst, input logic h);
        vec_t e;
        e.rst = r; e.src = s; e.take = tk; e.imm = im; e.jt = j; e.jr = jrv;
        e.halt = hl; e.hold = hd; e.pf = pf; e.v = v; e.pex = pex; e.inst = inst; e.h = h;
        tab.push_back(e);
    endtask

    task automatic model_edge();
        int  tgt;
        bit  taken;
        taken = (pc_src_ex == 2'd2) || (pc_src_ex == 2'd3) || (pc_src_ex == 2'd1 && branch_take_ex);
        case (pc_src_ex)
            2'd1:    tgt = (m_pex + 1 + int'($signed(imm_ex))) & MASK;
            2'd2:    tgt = int'(jtarget_ex) & MASK;
            2'd3:    tgt = int'(jr_target_ex) & MASK;
            default: tgt = m_pf;
        endcase
        if (rst) begin
            m_pf = 0; m_pex = 0; m_v = 1'b0; m_h = 1'b0; m_inst = 32'd0;
        end else if (!m_h && !hold) begin
            if (m_v) m_inst = m_inst + 32'd1;
            if (m_v && halt_ex) begin
                m_h = 1'b1; m_v = 1'b0;
            end else if (m_v && taken) begin
                m_pex = m_pf; m_pf = tgt; m_v = 1'b0;
            end else begin
                m_pex = m_pf; m_pf = (m_pf + 1) % 4096; m_v = 1'b1;
            end
        end
    endtask

    task automatic step(input bit use_tab, input vec_t e);
        @(negedge clk);
        if (m_ok) begin
            chk("ir_load", {31'd0, ir_load}, {31'd0, (!m_h && !hold)});
            chk("link_ex", 32'(link_ex), (m_pex + 1) & MASK);
        end
        model_edge();
        m_ok = 1'b1;
        @(posedge clk);
        #1;
        if (use_tab) begin
            chk("tab_pc_fetch", 32'(pc_fetch), e.pf);
            chk("tab_ex_valid", {31'd0, ex_valid}, {31'd0, e.v});
            chk("tab_pc_ex", 32'(pc_ex), e.pex);
            chk("tab_instret", instret, e.inst);
            chk("tab_halted", {31'd0, halted}, {31'd0, e.h});
        end else begin
            chk("rnd_pc_fetch", 32'(pc_fetch), m_pf);
            chk("rnd_ex_valid", {31'd0, ex_valid}, {31'd0, m_v});
            chk("rnd_pc_ex", 32'(pc_ex), m_pex);
            chk("rnd_instret", instret, m_inst);
            chk("rnd_halted", {31'd0, halted}, {31'd0, m_h});
        end
    endtask

    task automatic drive(input vec_t e);
        rst = e.rst; pc_src_ex = e.src; branch_take_ex = e.take; imm_ex = e.imm;
        jtarget_ex = e.jt; jr_target_ex = e.jr; halt_ex = e.halt; hold = e.hold;
    endtask

    initial begin
        vec_t e;
        // rst src tk imm jt jr halt hold | pf v pex inst h
        add(1, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0, k, 1, k - 1, k - 1, 0);
        add(0, 1, 1, 16'hFFFD, 26'd0, 32'd0, 0, 0,  6, 0, 9, 9, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  7, 1, 6, 9, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  8, 1, 7, 10, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  9, 1, 8, 11, 0);
        add(0, 1, 0, 16'hFFFD, 26'd0, 32'd0, 0, 0, 10, 1, 9, 12, 0);
        add(0, 2, 0, 16'd0, 26'd3, 32'd0, 0, 0,  3, 0, 10, 13, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  4, 1, 3, 13, 0);
        add(0, 3, 0, 16'd0, 26'd0, 32'h0000_1FFF, 0, 0, 'hFFF, 0, 4, 14, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  0, 1, 'hFFF, 14, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0,  1, 1, 0, 15, 0);
        for (int k = 0; k < 3; k++) add(0, 2, 0, 16'd0, 26'h40, 32'd0, 0, 1, 1, 1, 0, 15, 0);
        add(0, 2, 0, 16'd0, 26'h40, 32'd0, 0, 0, 'h40, 0, 1, 16, 0);
        add(0, 0, 0, 16'd0, 26'd0, 32'd0, 0, 0, 'h41, 1, 'h40, 16, 0);
        add(0, 1, 1, 16'd5, 26'd0, 32'd0, 1, 0, 'h41, 0, 'h40, 17, 1);
        add(0, 2, 0, 16'd0, 26'h200, 32'd0, 0, 0, 'h41, 0, 'h40, 17, 1);
        add(1, 0, 0, 16'd0, 26'd0, 32'd0, 1, 0,  0, 0, 0, 0, 0);
        add(0, 2, 0, 16'd0, 26'h100, 32'd0, 0, 0, 1, 1, 0, 0, 0);

        for (int i = 0; i < tab.size(); i++) begin
            drive(tab[i]);
            step(1'b1, tab[i]);
        end

        // Hold outranks halt, then the halt lands once hold drops.
        e = tab[1];
        e.halt = 1'b1; e.hold = 1'b1;
        drive(e); step(1'b0, e);
        step(1'b0, e);
        e.hold = 1'b0;
        drive(e); step(1'b0, e);
        chk("halt_after_hold", {31'd0, halted}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            e.rst  = ($urandom_range(0, 60) == 0);
            e.src  = 2'($urandom_range(0, 3));
            e.take = 1'($urandom);
            e.imm  = 16'($signed($urandom_range(0, 40)) - 20);
            e.jt   = 26'($urandom);
            e.jr   = $urandom;
            e.halt = ($urandom_range(0, 50) == 0);
            e.hold = ($urandom_range(0, 5) == 0);
            drive(e);
            step(1'b0, e);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
